// File: rtl/lab4_pkg.sv
// Shared constants and sizing helper for the serial pattern detector.
package lab4_pkg;

  localparam int          SEQ_PAT_LEN = 4;
  localparam logic [3:0]  SEQ_PATTERN = 4'b1011;
  localparam int          SEQ_CNT_W   = 8;

  // Bits needed to count 0..n inclusive.
  function automatic int fill_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int FILL_W = fill_width(SEQ_PAT_LEN);

endpackage

// File: rtl/seq_shift_reg.sv
// History shift register: newest bit enters at the LSB.
module seq_shift_reg #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         nRESET,
  input  logic         CLR,
  input  logic         EN,
  input  logic         D,
  output logic [W-1:0] Q
);

  // Clear wins over shift; hold when not enabled.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)  Q <= '0;
    else if (CLR) Q <= '0;
    else if (EN)  Q <= {Q[W-2:0], D};
  end

endmodule

// File: rtl/seq_detect_shift.sv
// Serial pattern detector with fill tracking, registered match pulse
// and saturating match counter; overlap mode is selectable per sample.
module seq_detect_shift
  import lab4_pkg::*;
#(
  parameter int                 PAT_LEN = SEQ_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = SEQ_PATTERN,
  parameter int                 CNT_W   = SEQ_CNT_W
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic               CLR,
  input  logic               EN,
  input  logic               D,
  input  logic               OVERLAP,
  output logic               MATCH,
  output logic [PAT_LEN-1:0] HIST,
  output logic [CNT_W-1:0]   COUNT
);

  localparam int              FW   = fill_width(PAT_LEN);
  localparam logic [FW-1:0]   FULL = FW'(PAT_LEN);

  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_n;
  logic [PAT_LEN-1:0] hist_n;
  logic               hit;

  seq_shift_reg #(.W(PAT_LEN)) u_shift (
    .CLK    (CLK),
    .nRESET (nRESET),
    .CLR    (CLR),
    .EN     (EN),
    .D      (D),
    .Q      (HIST)
  );

  // Prospective history/fill after this sample and the match decision.
  // The history is recomputed here so the hit is known on the same edge
  // the shift register captures it.
  always_comb begin
    hist_n = {HIST[PAT_LEN-2:0], D};
    fill_n = (fill == FULL) ? FULL : fill + 1'b1;
    hit    = (fill_n == FULL) && (hist_n == PATTERN);
  end

  // Fill counter: restarts on a non-overlapping hit so the next match
  // needs a full set of fresh bits.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)               fill <= '0;
    else if (CLR)              fill <= '0;
    else if (EN) begin
      if (hit && !OVERLAP)     fill <= '0;
      else                     fill <= fill_n;
    end
  end

  // Registered one-cycle match pulse.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)   MATCH <= 1'b0;
    else if (CLR)  MATCH <= 1'b0;
    else           MATCH <= EN && hit;
  end

  // Saturating match counter.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)                        COUNT <= '0;
    else if (CLR)                       COUNT <= '0;
    else if (EN && hit && COUNT != '1)  COUNT <= COUNT + 1'b1;
  end

endmodule

// File: tb/tb_seq_detect_shift.sv
// Self-checking bench: three detector configurations driven in parallel
// (default, 2-bit counter, all-zero pattern) against a behavioural model.
module tb_seq_detect_shift;

  logic CLK = 1'b0;
  logic nRESET = 1'b0;
  logic CLR = 1'b0;
  logic EN = 1'b0;
  logic D = 1'b0;
  logic OVERLAP = 1'b0;

  logic       m0, m1, m2;
  logic [3:0] h0, h1, h2;
  logic [7:0] c0;
  logic [1:0] c1;
  logic [7:0] c2;

  logic       match_o [3];
  logic [3:0] hist_o  [3];
  logic [7:0] cnt_o   [3];

  assign match_o[0] = m0;
  assign match_o[1] = m1;
  assign match_o[2] = m2;
  assign hist_o[0]  = h0;
  assign hist_o[1]  = h1;
  assign hist_o[2]  = h2;
  assign cnt_o[0]   = c0;
  assign cnt_o[1]   = {6'd0, c1};
  assign cnt_o[2]   = c2;

  seq_detect_shift u_def (
    .CLK(CLK), .nRESET(nRESET), .CLR(CLR), .EN(EN), .D(D), .OVERLAP(OVERLAP),
    .MATCH(m0), .HIST(h0), .COUNT(c0)
  );

  seq_detect_shift #(.CNT_W(2)) u_sat (
    .CLK(CLK), .nRESET(nRESET), .CLR(CLR), .EN(EN), .D(D), .OVERLAP(OVERLAP),
    .MATCH(m1), .HIST(h1), .COUNT(c1)
  );

  seq_detect_shift #(.PATTERN(4'b0000)) u_zero (
    .CLK(CLK), .nRESET(nRESET), .CLR(CLR), .EN(EN), .D(D), .OVERLAP(OVERLAP),
    .MATCH(m2), .HIST(h2), .COUNT(c2)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a window of the last four enabled bits, the number of
  // bits collected since the last restart, and the match tally.
  int pat  [3] = '{11, 11, 0};
  int cmax [3] = '{255, 3, 255};
  int mdl_hist [3];
  int mdl_bits [3];
  int mdl_cnt  [3];
  bit mdl_match[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mdl_hist[k] = 0; mdl_bits[k] = 0; mdl_cnt[k] = 0; mdl_match[k] = 0;
    end
  endtask

  task automatic model_edge(input bit d, input bit en, input bit clr, input bit ov);
    for (int k = 0; k < 3; k++) begin
      if (clr) begin
        mdl_hist[k] = 0; mdl_bits[k] = 0; mdl_cnt[k] = 0; mdl_match[k] = 0;
      end else if (en) begin
        mdl_hist[k] = (mdl_hist[k] * 2 + int'(d)) % 16;
        mdl_bits[k] = (mdl_bits[k] >= 4) ? 4 : mdl_bits[k] + 1;
        mdl_match[k] = (mdl_bits[k] == 4) && (mdl_hist[k] == pat[k]);
        if (mdl_match[k]) begin
          if (mdl_cnt[k] < cmax[k]) mdl_cnt[k] = mdl_cnt[k] + 1;
          if (!ov) mdl_bits[k] = 0;
        end
      end else begin
        mdl_match[k] = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic step(input bit d, input bit en, input bit clr, input bit ov);
    D = d; EN = en; CLR = clr; OVERLAP = ov;
    @(posedge CLK);
    model_edge(d, en, clr, ov);
    #1;
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (match_o[k] !== 1'b0 || hist_o[k] !== 4'd0 || cnt_o[k] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: match=%b hist=%b count=%0d required 0/0000/0",
                 k, match_o[k], hist_o[k], cnt_o[k]);
      end
    end
    model_reset();
    @(negedge CLK);
    nRESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_overlap();
    logic [6:0] s;
    bit exp;
    s = 7'b1011011;
    step(0, 0, 1, 1);
    for (int i = 0; i < 7; i++) begin
      step(s[6-i], 1, 0, 1);
      exp = (i == 3) || (i == 6);
      n_checks++;
      if (match_o[0] !== exp) begin
        n_fail++;
        $display("FAIL overlap_match bit%0d: got %b required %b", i + 1, match_o[0], exp);
      end
    end
    n_checks++;
    if (cnt_o[0] !== 8'd2 || hist_o[0] !== 4'b1011) begin
      n_fail++;
      $display("FAIL overlap_end: count=%0d hist=%b required 2/1011", cnt_o[0], hist_o[0]);
    end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] s;
    bit exp;
    s = 7'b1011011;
    step(0, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      step(s[6-i], 1, 0, 0);
      exp = (i == 3);
      n_checks++;
      if (match_o[0] !== exp) begin
        n_fail++;
        $display("FAIL nonoverlap_match bit%0d: got %b required %b", i + 1, match_o[0], exp);
      end
    end
    n_checks++;
    if (cnt_o[0] !== 8'd1 || hist_o[0] !== 4'b1011) begin
      n_fail++;
      $display("FAIL nonoverlap_end: count=%0d hist=%b required 1/1011", cnt_o[0], hist_o[0]);
    end
  endtask

  task automatic test_en_gaps();
    step(0, 0, 1, 1);
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      n_checks++;
      if (match_o[0] !== 1'b0 || hist_o[0] !== 4'b0010) begin
        n_fail++;
        $display("FAIL en_gap_hold%0d: match=%b hist=%b required 0/0010", i, match_o[0], hist_o[0]);
      end
    end
    step(1, 1, 0, 1);
    n_checks++;
    if (match_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL en_gap_early: match=%b required 0", match_o[0]);
    end
    step(1, 1, 0, 1);
    n_checks++;
    if (match_o[0] !== 1'b1 || cnt_o[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL en_gap_match: match=%b count=%0d required 1/1", match_o[0], cnt_o[0]);
    end
    step(1, 0, 0, 1);
    n_checks++;
    if (match_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL en_gap_pulse: match=%b required 0", match_o[0]);
    end
  endtask

  task automatic test_saturate();
    logic [12:0] s;
    int exp_cnt [4] = '{1, 2, 3, 3};
    int nm;
    s = 13'b1011011011011;
    nm = 0;
    step(0, 0, 1, 1);
    for (int i = 0; i < 13; i++) begin
      step(s[12-i], 1, 0, 1);
      if (i == 3 || i == 6 || i == 9 || i == 12) begin
        n_checks++;
        if (match_o[1] !== 1'b1 || cnt_o[1] !== 8'(exp_cnt[nm])) begin
          n_fail++;
          $display("FAIL saturate_match%0d: match=%b count=%0d required 1/%0d",
                   nm + 1, match_o[1], cnt_o[1], exp_cnt[nm]);
        end
        nm++;
      end
    end
    n_checks++;
    if (cnt_o[0] !== 8'd4) begin
      n_fail++;
      $display("FAIL saturate_wide: count=%0d required 4", cnt_o[0]);
    end
  endtask

  task automatic test_zero_pattern();
    bit exp;
    step(0, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 1);
      exp = (i >= 3);
      n_checks++;
      if (match_o[2] !== exp || cnt_o[2] !== 8'((i >= 3) ? i - 2 : 0)) begin
        n_fail++;
        $display("FAIL zero_pat sample%0d: match=%b count=%0d required %b/%0d",
                 i + 1, match_o[2], cnt_o[2], exp, (i >= 3) ? i - 2 : 0);
      end
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 1, 1);
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    #2;
    nRESET = 1'b0;
    #1;
    n_checks++;
    if (hist_o[0] !== 4'd0 || match_o[0] !== 1'b0 || cnt_o[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: hist=%b match=%b count=%0d required 0000/0/0",
               hist_o[0], match_o[0], cnt_o[0]);
    end
    model_reset();
    #1;
    nRESET = 1'b1;
    @(posedge CLK); #1;
    model_edge(D, EN, CLR, OVERLAP);
    mdl_match[0] = mdl_match[0];
    step(1, 1, 0, 1);
    n_checks++;
    if (match_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_post_first: match=%b required 0", match_o[0]);
    end
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    n_checks++;
    if (match_o[0] !== 1'b1 || cnt_o[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL async_post_match: match=%b count=%0d required 1/1", match_o[0], cnt_o[0]);
    end
    // Same scenario with the synchronous clear.
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    step(1, 1, 1, 1);
    n_checks++;
    if (hist_o[0] !== 4'd0 || match_o[0] !== 1'b0 || cnt_o[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_mid: hist=%b match=%b count=%0d required 0000/0/0",
               hist_o[0], match_o[0], cnt_o[0]);
    end
    step(1, 1, 0, 1);
    n_checks++;
    if (match_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_post_first: match=%b required 0", match_o[0]);
    end
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    n_checks++;
    if (match_o[0] !== 1'b1 || cnt_o[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL clr_post_match: match=%b count=%0d required 1/1", match_o[0], cnt_o[0]);
    end
  endtask

  task automatic test_random();
    bit d, en, clr, ov;
    step(0, 0, 1, 0);
    for (int i = 0; i < 400; i++) begin
      d   = $urandom_range(0, 1) == 1;
      en  = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 39) == 0;
      ov  = (i / 50) % 2 == 1 ? 1'b1 : ($urandom_range(0, 1) == 1);
      step(d, en, clr, ov);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (match_o[k] !== mdl_match[k] || hist_o[k] !== 4'(mdl_hist[k])
            || cnt_o[k] !== 8'(mdl_cnt[k])) begin
          n_fail++;
          $display("FAIL random[%0d] inst%0d: match=%b hist=%b count=%0d required %b/%b/%0d",
                   i, k, match_o[k], hist_o[k], cnt_o[k],
                   mdl_match[k], 4'(mdl_hist[k]), mdl_cnt[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_en_gaps();
    test_saturate();
    test_zero_pattern();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
